// File: rtl/matriz_pkg.sv
// matriz_pkg: shared sizes, state encoding, request payload and the
// power-on contents of the 8x8 matrix owned by matriz_ctrl.
package matriz_pkg;

    localparam int unsigned ROWS   = 8;
    localparam int unsigned COLS   = 8;
    localparam int unsigned DW     = 32;
    localparam int unsigned ROW_W  = 3;
    localparam int unsigned COL_W  = 3;
    localparam int unsigned IDX_W  = ROW_W + COL_W;
    localparam int unsigned NCELLS = ROWS * COLS;

    // Cells that come out of the init sweep with a non-zero value
    localparam int unsigned   INIT_R0 = 1;
    localparam int unsigned   INIT_C0 = 2;
    localparam logic [DW-1:0] INIT_V0 = 32'h0000_0123;
    localparam int unsigned   INIT_R1 = 3;
    localparam int unsigned   INIT_C1 = 4;
    localparam logic [DW-1:0] INIT_V1 = 32'h0000_0456;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    // One single-cell access as presented by a requester
    typedef struct packed {
        logic             we;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        logic [DW-1:0]    wdata;
    } req_t;

    // Value written into cell (row,col) by the init sweep
    function automatic logic [DW-1:0] init_value(input logic [ROW_W-1:0] row,
                                                 input logic [COL_W-1:0] col);
        logic [DW-1:0] v;
        v = '0;
        if (row == ROW_W'(INIT_R0) && col == COL_W'(INIT_C0)) v = INIT_V0;
        if (row == ROW_W'(INIT_R1) && col == COL_W'(INIT_C1)) v = INIT_V1;
        return v;
    endfunction

endpackage

// File: rtl/matriz_ctrl_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   clk, reset : clock, synchronous active-high reset
//   req[1:0]   : request lines
//   enable     : when low no grant is issued and priority is frozen
//   gnt[1:0]   : one-hot grant, combinational from req/enable/last_grant
module rr_arb2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       enable,
    output logic [1:0] gnt
);

    logic last_grant;

    // Lone requester wins; on contention the port not served last wins
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
                default: gnt = 2'b00;
            endcase
        end
    end

    // Reset to port 1 so port 0 wins the first contention
    always_ff @(posedge clk) begin
        if (reset) begin
            last_grant <= 1'b1;
        end else if (|gnt) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/matriz_ctrl.sv
// matriz_ctrl: owns the 8x8x32 matrix, initialises it with a 64-cycle sweep
// after reset or clr_start, and shares single-cell access between port 0
// (game/update) and port 1 (display/scan) with round-robin arbitration.
//   clk, reset          : clock, synchronous active-high reset
//   clr_start           : one-cycle request to re-run the init sweep
//   busy                : init sweep in progress
//   req_valid/req_ready : per-port handshake, ready is combinational
//   req_we/row/col/wdata: per-port access fields
//   rsp_valid/rsp_rdata : per-port read response, one cycle after handshake
module matriz_ctrl
    import matriz_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clr_start,
    output logic                     busy,
    input  logic [1:0]               req_valid,
    output logic [1:0]               req_ready,
    input  logic [1:0]               req_we,
    input  logic [1:0][ROW_W-1:0]    req_row,
    input  logic [1:0][COL_W-1:0]    req_col,
    input  logic [1:0][DW-1:0]       req_wdata,
    output logic [1:0]               rsp_valid,
    output logic [1:0][DW-1:0]       rsp_rdata
);

    state_t           state, state_nx;
    logic [IDX_W-1:0] idx, idx_nx;
    logic [DW-1:0]    mem [ROWS][COLS];

    logic             arb_en;
    logic [1:0]       gnt;
    logic             gnt_port;
    req_t             sel_req;
    logic             wr_en;
    logic             rd_en;
    logic [ROW_W-1:0] init_row;
    logic [COL_W-1:0] init_col;

    // A clear request in S_RUN takes the cycle: nobody is granted
    assign arb_en = (state == S_RUN) && !clr_start;

    rr_arb2 u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .enable (arb_en),
        .gnt    (gnt)
    );

    assign req_ready = gnt;
    assign busy      = (state == S_INIT);

    // Route the granted port's fields to the storage
    always_comb begin
        gnt_port      = gnt[1];
        sel_req.we    = req_we[gnt_port];
        sel_req.row   = req_row[gnt_port];
        sel_req.col   = req_col[gnt_port];
        sel_req.wdata = req_wdata[gnt_port];
    end

    assign wr_en    = (|gnt) && sel_req.we;
    assign rd_en    = (|gnt) && !sel_req.we;
    assign init_row = idx[IDX_W-1:COL_W];
    assign init_col = idx[COL_W-1:0];

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_INIT;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    // Next state: sweep all cells once, then serve until a clear request
    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        case (state)
            S_INIT: begin
                idx_nx = idx + IDX_W'(1);
                if (idx == IDX_W'(NCELLS - 1)) state_nx = S_RUN;
            end
            S_RUN: begin
                if (clr_start) begin
                    state_nx = S_INIT;
                    idx_nx   = '0;
                end
            end
            default: begin
                state_nx = S_INIT;
                idx_nx   = '0;
            end
        endcase
    end

    // Storage: sweep writes in S_INIT, granted writes in S_RUN
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (state == S_INIT) begin
                mem[init_row][init_col] <= init_value(init_row, init_col);
            end else if (wr_en) begin
                mem[sel_req.row][sel_req.col] <= sel_req.wdata;
            end
        end
    end

    // Read response: valid pulses one cycle, data holds until the next read
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= '0;
            if (rd_en) begin
                rsp_valid[gnt_port] <= 1'b1;
                rsp_rdata[gnt_port] <= mem[sel_req.row][sel_req.col];
            end
        end
    end

endmodule

// File: tb/tb_matriz_ctrl.sv
module tb_matriz_ctrl;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             clr_start = 1'b0;
    logic             busy;
    logic [1:0]       req_valid = 2'b00;
    logic [1:0]       req_ready;
    logic [1:0]       req_we = 2'b00;
    logic [1:0][2:0]  req_row = '0;
    logic [1:0][2:0]  req_col = '0;
    logic [1:0][31:0] req_wdata = '0;
    logic [1:0]       rsp_valid;
    logic [1:0][31:0] rsp_rdata;

    matriz_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .clr_start (clr_start),
        .busy      (busy),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_row   (req_row),
        .req_col   (req_col),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]      m_mem [8][8];
    int               m_left = 0;     // init cycles still to run
    int               m_last = 1;     // port served most recently
    logic [1:0]       m_rv = 2'b00;
    logic [1:0][31:0] m_rd = '0;
    bit               m_ok = 0;

    task automatic fill_defaults();
        for (int r = 0; r < 8; r++)
            for (int c = 0; c < 8; c++)
                m_mem[r][c] = (r == 1 && c == 2) ? 32'h123 :
                              (r == 3 && c == 4) ? 32'h456 : 32'h0;
    endtask

    function automatic logic [1:0] exp_rdy();
        if (m_left > 0 || clr_start) return 2'b00;
        if (req_valid == 2'b11) return (m_last == 0) ? 2'b10 : 2'b01;
        return req_valid;
    endfunction

    always @(posedge clk) begin : model
        logic [1:0] er;
        int g;
        if (reset) begin
            m_ok   = 1;
            m_left = 64;
            m_last = 1;
            m_rv   = 2'b00;
            m_rd   = '0;
            fill_defaults();
        end else if (m_ok) begin
            er   = exp_rdy();
            m_rv = 2'b00;
            if (m_left > 0) begin
                m_left--;
            end else if (clr_start) begin
                m_left = 64;
                fill_defaults();
            end else if (er != 2'b00) begin
                g = er[1] ? 1 : 0;
                m_last = g;
                if (req_we[g]) begin
                    m_mem[req_row[g]][req_col[g]] = req_wdata[g];
                end else begin
                    m_rv[g] = 1'b1;
                    m_rd[g] = m_mem[req_row[g]][req_col[g]];
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    int gnt_log[$];
    int rsp_cnt[2] = '{0, 0};

    always @(negedge clk) begin
        if (m_ok) begin
            chk("busy", 64'(busy), 64'(m_left > 0));
            chk("req_ready", 64'(req_ready), 64'(exp_rdy()));
            chk("rsp_valid", 64'(rsp_valid), 64'(m_rv));
            chk("rsp_rdata0", 64'(rsp_rdata[0]), 64'(m_rd[0]));
            chk("rsp_rdata1", 64'(rsp_rdata[1]), 64'(m_rd[1]));
            if (req_ready[0]) gnt_log.push_back(0);
            if (req_ready[1]) gnt_log.push_back(1);
            for (int p = 0; p < 2; p++) if (rsp_valid[p]) rsp_cnt[p]++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Waits (at negedges) for ready on port p; n = negedges seen, nb = of those with busy
    task automatic wait_ready(input int p, output int n, output int nb);
        n = 0;
        nb = 0;
        forever begin
            @(negedge clk);
            n++;
            if (busy) nb++;
            if (req_ready[p]) break;
            if (n > 300) begin
                checks++;
                errors++;
                $display("FAIL ready_timeout port %0d: got no ready expected ready within 300 cycles", p);
                break;
            end
        end
    endtask

    task automatic count_busy(output int nb);
        nb = 0;
        forever begin
            @(negedge clk);
            if (!busy) break;
            nb++;
            if (nb > 300) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: got busy stuck expected low within 300 cycles");
                break;
            end
        end
    endtask

    task automatic set_req(input int p, input logic we, input int r, input int c, input logic [31:0] d);
        req_we[p]    = we;
        req_row[p]   = 3'(r);
        req_col[p]   = 3'(c);
        req_wdata[p] = d;
        req_valid[p] = 1'b1;
    endtask

    task automatic xfer(input int p, input logic we, input int r, input int c,
                        input logic [31:0] d, input logic [31:0] exp_rd);
        int n, nb;
        set_req(p, we, r, c, d);
        wait_ready(p, n, nb);
        step(1);
        req_valid[p] = 1'b0;
        if (!we) begin
            @(negedge clk);
            chk("xfer_rsp_valid", 64'(rsp_valid[p]), 64'd1);
            chk("xfer_rdata", 64'(rsp_rdata[p]), 64'(exp_rd));
            step(1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before 100us");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        int n, nb;

        // Reset state, then a port-0 read held through the whole sweep
        step(2);
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rdata0", 64'(rsp_rdata[0]), 64'd0);
        chk("reset_busy", 64'(busy), 64'd1);
        step(1);
        reset = 1'b0;
        set_req(0, 1'b0, 1, 2, 32'h0);
        wait_ready(0, n, nb);
        chk("init_ready_cycle", 64'(n), 64'd65);
        chk("init_busy_cycles", 64'(nb), 64'd64);
        step(1);
        req_valid[0] = 1'b0;
        @(negedge clk);
        chk("held_rsp_valid", 64'(rsp_valid[0]), 64'd1);
        chk("held_rdata_1_2", 64'(rsp_rdata[0]), 64'h123);
        step(1);
        @(negedge clk);
        chk("held_single_xfer", 64'(rsp_valid), 64'd0);
        step(1);

        // Default contents
        xfer(0, 1'b0, 3, 4, 32'h0, 32'h456);
        xfer(0, 1'b0, 0, 0, 32'h0, 32'h0);

        // Write on port 0, read back on port 1
        xfer(0, 1'b1, 5, 6, 32'hDEADBEEF, 32'h0);
        xfer(1, 1'b0, 5, 6, 32'h0, 32'hDEADBEEF);

        // Sustained contention alternates starting with port 0
        gnt_log.delete();
        rsp_cnt = '{0, 0};
        set_req(0, 1'b0, 3, 4, 32'h0);
        set_req(1, 1'b0, 5, 6, 32'h0);
        step(6);
        req_valid = 2'b00;
        step(1);
        chk("contend_ngrants", 64'(gnt_log.size()), 64'd6);
        for (int i = 0; i < gnt_log.size() && i < 6; i++)
            chk($sformatf("contend_grant%0d", i), 64'(gnt_log[i]), 64'(i % 2));
        chk("contend_rsp0", 64'(rsp_cnt[0]), 64'd3);
        chk("contend_rsp1", 64'(rsp_cnt[1]), 64'd3);
        chk("contend_rdata0", 64'(rsp_rdata[0]), 64'h456);
        chk("contend_rdata1", 64'(rsp_rdata[1]), 64'hDEADBEEF);

        // Overwrite a default cell, then clear while port 1 is waiting
        xfer(0, 1'b1, 1, 2, 32'h7, 32'h0);
        xfer(1, 1'b0, 1, 2, 32'h0, 32'h7);
        set_req(1, 1'b0, 1, 2, 32'h0);
        clr_start = 1'b1;
        @(negedge clk);
        chk("clr_no_grant", 64'(req_ready), 64'd0);
        step(1);
        clr_start = 1'b0;
        wait_ready(1, n, nb);
        chk("clr_ready_cycle", 64'(n), 64'd65);
        chk("clr_busy_cycles", 64'(nb), 64'd64);
        step(1);
        req_valid[1] = 1'b0;
        @(negedge clk);
        chk("clr_rdata_1_2", 64'(rsp_rdata[1]), 64'h123);
        step(1);

        // Reset in the middle of the sweep (idx 20)
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        step(20);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        count_busy(nb);
        chk("midsweep_busy_cycles", 64'(nb), 64'd64);
        step(1);
        xfer(0, 1'b0, 3, 4, 32'h0, 32'h456);

        // Reset landing on the same edge as a read grant
        set_req(0, 1'b0, 3, 4, 32'h0);
        wait_ready(0, n, nb);
        chk("run_ready_immediate", 64'(n), 64'd1);
        reset = 1'b1;
        step(1);
        @(negedge clk);
        chk("run_reset_rsp_cleared", 64'(rsp_valid), 64'd0);
        chk("run_reset_rdata_cleared", 64'(rsp_rdata[0]), 64'd0);
        step(1);
        reset = 1'b0;
        req_valid[0] = 1'b0;
        count_busy(nb);
        chk("run_reset_busy_cycles", 64'(nb), 64'd64);
        step(1);
        xfer(1, 1'b0, 1, 2, 32'h0, 32'h123);

        step(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
